// File: rtl/reg_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_write_ctrl_if : request ports A/B and register-file write bus
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface reg_write_ctrl_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_reg;
  logic        a_w;
  logic        a_dbl;
  logic [31:0] a_data;

  logic        b_valid;
  logic        b_ready;
  logic [2:0]  b_reg;
  logic        b_w;
  logic        b_dbl;
  logic [31:0] b_data;

  logic [11:0] we;
  logic [15:0] data;
  logic        sel_h_l;
  logic        busy;

  modport master (
    output a_valid, a_reg, a_w, a_dbl, a_data,
    output b_valid, b_reg, b_w, b_dbl, b_data,
    input  a_ready, b_ready, we, data, sel_h_l, busy
  );

  modport slave (
    input  a_valid, a_reg, a_w, a_dbl, a_data,
    input  b_valid, b_reg, b_w, b_dbl, b_data,
    output a_ready, b_ready, we, data, sel_h_l, busy
  );
endinterface

`default_nettype wire

// File: rtl/reg_write_ctrl.sv
// ---------------------------------------------------------------------------
// reg_write_ctrl : two-port 8086 register-file write controller.
// Macro REG_WRITE_CTRL_RR_ARB_EN selects round-robin (else A-priority) arbitration.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_write_ctrl (
  input  wire logic        clk,
  input  wire logic        rst,   // synchronous, active-low
  reg_write_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WRITE_HI = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] we_q,    we_d;
  logic [15:0] data_q,  data_d;
  logic        sel_q,   sel_d;
  logic [15:0] hi_q,    hi_d;

  logic        grant_a;
  logic        grant_b;
  logic        xfer;
  logic [2:0]  x_reg;
  logic        x_w;
  logic        x_dbl;
  logic [31:0] x_data;
  logic [3:0]  idx_lo;
  logic [3:0]  idx_hi;

`ifdef REG_WRITE_CTRL_RR_ARB_EN
  // rr_q = 1 means B is favoured when both ports request
  logic rr_q, rr_d;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst && (state_q != WRITE_HI)) begin
      grant_a = bus.a_valid && (!bus.b_valid || !rr_q);
      grant_b = bus.b_valid && (!bus.a_valid ||  rr_q);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_a)
      rr_d = 1'b1;
    else if (grant_b)
      rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      rr_q <= 1'b0;
    else
      rr_q <= rr_d;
  end
`else
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst && (state_q != WRITE_HI)) begin
      grant_a = bus.a_valid;
      grant_b = bus.b_valid && !bus.a_valid;
    end
  end
`endif

  assign xfer        = grant_a || grant_b;
  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  always_comb begin
    if (grant_b) begin
      x_reg  = bus.b_reg;
      x_w    = bus.b_w;
      x_dbl  = bus.b_dbl;
      x_data = bus.b_data;
    end else begin
      x_reg  = bus.a_reg;
      x_w    = bus.a_w;
      x_dbl  = bus.a_dbl;
      x_data = bus.a_data;
    end
  end

  // Byte regs sit at WE[11:4], word regs SP..DI at WE[3:0]
  assign idx_lo = 4'd11 - {1'b0, x_reg};
  assign idx_hi = 4'd7  - {1'b0, x_reg};

  always_comb begin
    state_d = IDLE;
    we_d    = 12'h000;
    data_d  = 16'h0000;
    sel_d   = 1'b0;
    hi_d    = hi_q;
    if (state_q == WRITE_HI) begin
      we_d   = 12'h220;
      data_d = hi_q;
      sel_d  = 1'b1;
    end else if (xfer) begin
      if (x_dbl) begin
        state_d = WRITE_HI;
        we_d    = 12'h880;
        data_d  = x_data[15:0];
        sel_d   = 1'b1;
        hi_d    = x_data[31:16];
      end else begin
        state_d = WRITE;
        if (!x_w) begin
          we_d   = 12'd1 << idx_lo;
          data_d = {8'h00, x_data[7:0]};
        end else if (!x_reg[2]) begin
          we_d   = (12'd1 << idx_lo) | (12'd1 << idx_hi);
          data_d = x_data[15:0];
          sel_d  = 1'b1;
        end else begin
          we_d   = 12'd1 << idx_hi;
          data_d = x_data[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 12'h000;
      data_q  <= 16'h0000;
      sel_q   <= 1'b0;
      hi_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.we      = we_q;
  assign bus.data    = data_q;
  assign bus.sel_h_l = sel_q;
  assign bus.busy    = (state_q == WRITE_HI);

endmodule

`default_nettype wire

// File: tb/tb_reg_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_write_ctrl : directed self-checking bench with a register-file model
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_write_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_write_ctrl_if bus ();

  reg_write_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: index 0..7 = AL CL DL BL AH CH DH BH; rf16 = SP BP SI DI
  logic [7:0]  rf8  [8];
  logic [15:0] rf16 [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.we[11-i]) rf8[i]   <= bus.data[7:0];
      if (bus.we[7-i])  rf8[4+i] <= bus.sel_h_l ? bus.data[15:8] : bus.data[7:0];
      if (bus.we[3-i])  rf16[i]  <= bus.data;
    end
  end

  typedef struct packed {
    logic [2:0]  r;
    logic        w;
    logic [15:0] d;
    logic [11:0] we;
    logic [15:0] ed;
    logic        sel;
  } vec_t;

  vec_t tab [7];

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_reg = 3'd0; bus.a_w = 1'b0; bus.a_dbl = 1'b0; bus.a_data = 32'h0;
    bus.b_valid = 1'b0; bus.b_reg = 3'd0; bus.b_w = 1'b0; bus.b_dbl = 1'b0; bus.b_data = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    bus.a_valid = 1'b1;
    #1;
    checks++; if (bus.we !== 12'h000) begin failures++; $display("FAIL reset_we got %h exp 000", bus.we); end
    checks++; if (bus.data !== 16'h0000) begin failures++; $display("FAIL reset_data got %h exp 0000", bus.data); end
    checks++; if (bus.sel_h_l !== 1'b0) begin failures++; $display("FAIL reset_sel got %b exp 0", bus.sel_h_l); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready got %b exp 0", bus.a_ready); end
    checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("FAIL reset_b_ready got %b exp 0", bus.b_ready); end
    bus.a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_byte_high();
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_reg = 3'd4; bus.a_w = 1'b0; bus.a_dbl = 1'b0; bus.a_data = 32'h0000_005A;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL ah_ready got %b exp 1", bus.a_ready); end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    checks++; if (bus.we !== 12'h080) begin failures++; $display("FAIL ah_we got %h exp 080", bus.we); end
    checks++; if (bus.data !== 16'h005A) begin failures++; $display("FAIL ah_data got %h exp 005a", bus.data); end
    checks++; if (bus.sel_h_l !== 1'b0) begin failures++; $display("FAIL ah_sel got %b exp 0", bus.sel_h_l); end
    @(posedge clk); #1;
    checks++; if (rf8[4] !== 8'h5A) begin failures++; $display("FAIL ah_rf got %h exp 5a", rf8[4]); end
    checks++; if (bus.we !== 12'h000) begin failures++; $display("FAIL ah_idle_we got %h exp 000", bus.we); end
    checks++; if (bus.data !== 16'h0000) begin failures++; $display("FAIL ah_idle_data got %h exp 0000", bus.data); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_reg = 3'd1; bus.a_w = 1'b1; bus.a_dbl = 1'b0; bus.a_data = 32'h0000_BEEF;
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_reg = 3'd6; bus.b_w = 1'b1; bus.b_dbl = 1'b0; bus.b_data = 32'h0000_1234;
    checks++; if (bus.we !== 12'h440) begin failures++; $display("FAIL cx_we got %h exp 440", bus.we); end
    checks++; if (bus.data !== 16'hBEEF) begin failures++; $display("FAIL cx_data got %h exp beef", bus.data); end
    checks++; if (bus.sel_h_l !== 1'b1) begin failures++; $display("FAIL cx_sel got %b exp 1", bus.sel_h_l); end
    #1;
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL si_ready got %b exp 1", bus.b_ready); end
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    checks++; if (bus.we !== 12'h002) begin failures++; $display("FAIL si_we got %h exp 002", bus.we); end
    checks++; if (bus.data !== 16'h1234) begin failures++; $display("FAIL si_data got %h exp 1234", bus.data); end
    checks++; if (bus.sel_h_l !== 1'b0) begin failures++; $display("FAIL si_sel got %b exp 0", bus.sel_h_l); end
    checks++; if ({rf8[5], rf8[1]} !== 16'hBEEF) begin failures++; $display("FAIL cx_rf got %h exp beef", {rf8[5], rf8[1]}); end
    @(posedge clk); #1;
    checks++; if (rf16[2] !== 16'h1234) begin failures++; $display("FAIL si_rf got %h exp 1234", rf16[2]); end
  endtask

  task automatic test_decode();
    tab[0] = '{3'd0, 1'b0, 16'h1234, 12'h800, 16'h0034, 1'b0};
    tab[1] = '{3'd3, 1'b0, 16'h00AB, 12'h100, 16'h00AB, 1'b0};
    tab[2] = '{3'd7, 1'b0, 16'h5599, 12'h010, 16'h0099, 1'b0};
    tab[3] = '{3'd2, 1'b1, 16'h5566, 12'h220, 16'h5566, 1'b1};
    tab[4] = '{3'd3, 1'b1, 16'h7788, 12'h110, 16'h7788, 1'b1};
    tab[5] = '{3'd4, 1'b1, 16'h0102, 12'h008, 16'h0102, 1'b0};
    tab[6] = '{3'd7, 1'b1, 16'hFEDC, 12'h001, 16'hFEDC, 1'b0};
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_dbl = 1'b0;
    bus.a_reg = tab[0].r; bus.a_w = tab[0].w; bus.a_data = {16'hFFFF, tab[0].d};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.we !== tab[i].we) begin failures++; $display("FAIL dec%0d_we got %h exp %h", i, bus.we, tab[i].we); end
      checks++; if (bus.data !== tab[i].ed) begin failures++; $display("FAIL dec%0d_data got %h exp %h", i, bus.data, tab[i].ed); end
      checks++; if (bus.sel_h_l !== tab[i].sel) begin failures++; $display("FAIL dec%0d_sel got %b exp %b", i, bus.sel_h_l, tab[i].sel); end
      if (i < 6) begin
        bus.a_reg = tab[i+1].r; bus.a_w = tab[i+1].w; bus.a_data = {16'hFFFF, tab[i+1].d};
      end else begin
        bus.a_valid = 1'b0;
      end
    end
  endtask

  task automatic test_dbl();
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_dbl = 1'b1; bus.a_reg = 3'd5; bus.a_w = 1'b0; bus.a_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.a_dbl = 1'b0; bus.a_data = 32'h1111_2222;
    bus.b_valid = 1'b1; bus.b_reg = 3'd0; bus.b_w = 1'b1; bus.b_data = 32'h3333_4444;
    #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL dbl_busy got %b exp 1", bus.busy); end
    checks++; if (bus.a_ready !== 1'b0) begin failures++; $display("FAIL dbl_a_ready got %b exp 0", bus.a_ready); end
    checks++; if (bus.b_ready !== 1'b0) begin failures++; $display("FAIL dbl_b_ready got %b exp 0", bus.b_ready); end
    checks++; if (bus.we !== 12'h880) begin failures++; $display("FAIL dbl_ax_we got %h exp 880", bus.we); end
    checks++; if (bus.data !== 16'hF00D) begin failures++; $display("FAIL dbl_ax_data got %h exp f00d", bus.data); end
    checks++; if (bus.sel_h_l !== 1'b1) begin failures++; $display("FAIL dbl_ax_sel got %b exp 1", bus.sel_h_l); end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.we !== 12'h220) begin failures++; $display("FAIL dbl_dx_we got %h exp 220", bus.we); end
    checks++; if (bus.data !== 16'hCAFE) begin failures++; $display("FAIL dbl_dx_data got %h exp cafe", bus.data); end
    checks++; if (bus.sel_h_l !== 1'b1) begin failures++; $display("FAIL dbl_dx_sel got %b exp 1", bus.sel_h_l); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL dbl_dx_busy got %b exp 0", bus.busy); end
    @(posedge clk); #1;
    checks++; if ({rf8[4], rf8[0]} !== 16'hF00D) begin failures++; $display("FAIL dbl_ax_rf got %h exp f00d", {rf8[4], rf8[0]}); end
    checks++; if ({rf8[6], rf8[2]} !== 16'hCAFE) begin failures++; $display("FAIL dbl_dx_rf got %h exp cafe", {rf8[6], rf8[2]}); end
  endtask

  task automatic test_reset_in_write_hi();
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_dbl = 1'b1; bus.a_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.a_dbl = 1'b0;
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rsthi_busy_pre got %b exp 1", bus.busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (bus.we !== 12'h000) begin failures++; $display("FAIL rsthi_we got %h exp 000", bus.we); end
    checks++; if (bus.data !== 16'h0000) begin failures++; $display("FAIL rsthi_data got %h exp 0000", bus.data); end
    checks++; if (bus.sel_h_l !== 1'b0) begin failures++; $display("FAIL rsthi_sel got %b exp 0", bus.sel_h_l); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rsthi_busy got %b exp 0", bus.busy); end
    @(posedge clk); #1;
    checks++; if ({rf8[6], rf8[2]} !== 16'hCAFE) begin failures++; $display("FAIL rsthi_dx_rf got %h exp cafe", {rf8[6], rf8[2]}); end
    checks++; if (bus.we !== 12'h000) begin failures++; $display("FAIL rsthi_we2 got %h exp 000", bus.we); end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_a;
    logic [3:0] exp_b;
`ifdef REG_WRITE_CTRL_RR_ARB_EN
    exp_a = 4'b0101;  // cycle i at bit i: A,B,A,B
    exp_b = 4'b1010;
`else
    exp_a = 4'b1111;
    exp_b = 4'b0000;
`endif
    @(negedge clk);
    bus.a_valid = 1'b1; bus.a_reg = 3'd0; bus.a_w = 1'b1; bus.a_dbl = 1'b0; bus.a_data = 32'h0000_AAAA;
    bus.b_valid = 1'b1; bus.b_reg = 3'd4; bus.b_w = 1'b1; bus.b_dbl = 1'b0; bus.b_data = 32'h0000_BBBB;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.a_ready !== exp_a[i]) begin failures++; $display("FAIL arb%0d_a_ready got %b exp %b", i, bus.a_ready, exp_a[i]); end
      checks++; if (bus.b_ready !== exp_b[i]) begin failures++; $display("FAIL arb%0d_b_ready got %b exp %b", i, bus.b_ready, exp_b[i]); end
      @(posedge clk); #1;
      checks++;
      if (bus.we !== (exp_a[i] ? 12'h880 : 12'h008)) begin
        failures++;
        $display("FAIL arb%0d_we got %h exp %h", i, bus.we, exp_a[i] ? 12'h880 : 12'h008);
      end
      @(negedge clk);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_byte_high();
    test_back_to_back();
    test_decode();
    test_dbl();
    test_reset_in_write_hi();
    test_arbitration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the test sequence ended");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have RST  in  1  reset, synchronous, active-low.
REQ-003 SHALL have A_VALID  in  1  port A (execute writeback) request; B_VALID  in  1  port B (stack unit) request.
REQ-004 SHALL have A_REG, B_REG  in  3  register field, 8086 encoding.
REQ-005 SHALL have A_W, B_W  in  1  width: 0 = byte, 1 = word.
REQ-006 SHALL have A_DBL, B_DBL  in  1  double write: DX:AX from 32-bit data; REG and W ignored.
REQ-007 SHALL have A_DATA, B_DATA  in  32  write data; [15:0] used unless DBL.
REQ-008 SHALL have A_READY, B_READY  out  1  accept strobe; transfer occurs when VALID and READY are both high at a rising edge.
REQ-009 SHALL have WE  out  12  register-file write enables: 11 AL, 10 CL, 9 DL, 8 BL, 7 AH, 6 CH, 5 DH, 4 BH, 3 SP, 2 BP, 1 SI, 0 DI.
REQ-010 SHALL have DATA  out  16  register-file data; SEL_H_L  out  1  high-byte mux select.
REQ-011 SHALL have BUSY  out  1  high in state WRITE_HI.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, WRITE_HI.
REQ-013 IDLE or WRITE, no transfer -> IDLE. Single transfer -> WRITE. DBL transfer -> WRITE_HI. WRITE_HI -> IDLE unconditionally.
REQ-014 READY SHALL be combinational: low for both ports in WRITE_HI; otherwise high only for the arbitration winner among valid ports.
REQ-015 Arbitration SHALL grant at most one port per cycle. Requesters SHALL hold VALID and payload until accepted.
REQ-016 WE, DATA and SEL_H_L SHALL be registered. A transfer at edge N drives the write during cycle N+1, so the register file captures it at edge N+2.
REQ-017 W=0, REG 0-3: WE bit 11-REG set; DATA = {8'h00, byte}; SEL_H_L=0.
REQ-018 W=0, REG 4-7: WE bit 11-REG set (AH..BH); byte on DATA[7:0]; SEL_H_L=0.
REQ-019 W=1, REG 0-3: WE bits 11-REG and 7-REG set; DATA = word; SEL_H_L=1.
REQ-020 W=1, REG 4-7: WE bit 7-REG set (SP..DI); DATA = word; SEL_H_L=0.
REQ-021 DBL: first cycle writes AX (WE=12'h880, DATA=[15:0], SEL_H_L=1). Following cycle (WRITE_HI) writes DX (WE=12'h220, DATA=[31:16], SEL_H_L=1). The upper half SHALL be latched at transfer.
REQ-022 In any cycle without a write, WE=0, DATA=0 and SEL_H_L=0.
REQ-023 Back-to-back single transfers SHALL sustain one write per cycle with no bubble.
REQ-024 WE SHALL be exactly one register set per REQ-017..021; no other bits SHALL be set.

Reset
REQ-025 When RST=0 at an edge, the next cycle SHALL show: state IDLE, WE=0, DATA=0, SEL_H_L=0, BUSY=0, READY both 0, and the round-robin pointer favouring A.
REQ-026 RST asserted in WRITE_HI SHALL drop the pending DX write.
REQ-027 A write already registered SHALL be cleared by reset and not issued.

Configuration
REQ-028 Macro REG_WRITE_CTRL_RR_ARB_EN.
- Defined: round-robin arbitration. When both ports are valid, grant goes to the port not granted last. The pointer updates only on transfer.
- Undefined: fixed priority, A always wins, B is granted only when A_VALID=0, and no pointer state is built.

Verification
REQ-029 A: REG=4, W=0, DATA=32'h5A -> cycle N+1: WE=12'h080, DATA=16'h005A, SEL_H_L=0; AH=8'h5A after edge N+2.
REQ-030 A: REG=1, W=1, DATA=16'hBEEF -> WE=12'h440, SEL_H_L=1; CL=EF, CH=BE. Then B: REG=6, W=1, 16'h1234 next cycle -> WE=12'h002, no bubble.
REQ-031 A: DBL, DATA=32'hCAFE_F00D -> WE 880 (DATA F00D), then 220 (DATA CAFE). BUSY=1 and both READY=0 in the second cycle. AX=F00D, DX=CAFE.
REQ-032 Both ports continuously valid for 4 cycles -> with _EN, grants A,B,A,B; without, grants A,A,A,A with B_READY=0.
REQ-033 RST=0 for one edge during WRITE_HI of a DBL -> the DX write is absent, WE=0 the next cycle, and the FSM is IDLE.
